// File: rtl/bcd_double_dabble_pkg.sv
// rtl/bcd_double_dabble_pkg.sv - shared types and constants for the binary-to-BCD converter
package bcd_double_dabble_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W_DEF   = 14;
  localparam int DIGITS_DEF  = 4;

  // Largest decimal value that fits in the given number of digits (10^digits - 1).
  function automatic logic [63:0] max_dec_value(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  // Packed BCD pattern with every digit set to 9, used as the saturation result.
  function automatic logic [63:0] all_nines(input int digits);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < digits; i++) begin
      v = (v << BCD_DIGIT_W) | 64'h9;
    end
    return v;
  endfunction

  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(BIN_W_DEF);

endpackage

// File: rtl/bcd_double_dabble_add3.sv
// rtl/bcd_double_dabble_add3.sv - double-dabble digit correction, +3 when digit >= 5
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_double_dabble.sv
// rtl/bcd_double_dabble.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
module bcd_double_dabble
  import bcd_double_dabble_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BIN_W-1:0]                bin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
  output logic                            overflow
);

  localparam int                BCD_W   = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W   = cnt_width(BIN_W);
  localparam logic [63:0]       MAX_VAL = max_dec_value(DIGITS);
  localparam logic [BCD_W-1:0]  NINES   = BCD_W'(all_nines(DIGITS));

  state_e              r_state;
  state_e              w_next_state;
  logic [BIN_W-1:0]    r_shreg;
  logic [BCD_W-1:0]    r_scratch;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_pend;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_overflow;
  logic                r_done;

  logic                w_accept;
  logic                w_last;
  logic [BCD_W-1:0]    w_adj;
  logic [BCD_W-1:0]    w_shifted;
  logic                w_unused_top;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The top scratch bit falls off on out-of-range inputs; saturation covers that case.
  assign w_shifted    = {w_adj[BCD_W-2:0], r_shreg[BIN_W-1]};
  assign w_unused_top = w_adj[BCD_W-1];

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_shreg    <= bin;
        r_scratch  <= '0;
        r_cnt      <= CNT_W'(BIN_W);
        r_ovf_pend <= (64'(bin) > MAX_VAL);
      end else if (r_state == SHIFT) begin
        r_scratch <= w_shifted;
        r_shreg   <= {r_shreg[BIN_W-2:0], 1'b0};
        r_cnt     <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_bcd      <= r_ovf_pend ? NINES : w_shifted;
          r_overflow <= r_ovf_pend;
        end
      end
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_double_dabble.sv
// tb/tb_bcd_double_dabble.sv - self-checking bench for bcd_double_dabble
module tb_bcd_double_dabble;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [13:0] b;
    logic [15:0] e_bcd;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  bcd_double_dabble #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  // Reference: decimal digits by division, saturated to 9999 with overflow flag.
  function automatic logic [16:0] model(input int v);
    logic [15:0] r;
    int          t;
    if (v > 9999) return {1'b1, 16'h9999};
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {1'b0, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Start one conversion, then follow it to done; checks latency, busy length, result, done width.
  task automatic do_conv(input logic [13:0] b, input logic [15:0] e_bcd, input logic e_ovf);
    int lat;
    int busy_n;
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 14);
    chk("busy_len", busy_n, 14);
    chk("busy_at_done", busy, 0);
    chk("bcd", bcd, e_bcd);
    chk("overflow", overflow, e_ovf);
    @(negedge clk);
    chk("done_fall", done, 0);
  endtask

  initial begin
    int          n_done;
    int          n_busy;
    int          first;
    int          m;
    logic [16:0] r;
    logic [13:0] b;
    logic [15:0] prev;

    tbl[0] = '{14'd1234,  16'h1234, 1'b0};
    tbl[1] = '{14'd0,     16'h0000, 1'b0};
    tbl[2] = '{14'd9999,  16'h9999, 1'b0};
    tbl[3] = '{14'd10000, 16'h9999, 1'b1};
    tbl[4] = '{14'd16383, 16'h9999, 1'b1};
    tbl[5] = '{14'd42,    16'h0042, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    chk("idle_done", n_done, 0);
    chk("idle_busy", n_busy, 0);
    chk("idle_bcd", bcd, 16'h0000);
    chk("idle_ovf", overflow, 0);

    foreach (tbl[i]) do_conv(tbl[i].b, tbl[i].e_bcd, tbl[i].e_ovf);

    prev = 16'h0;
    for (int i = 0; i < 30; i++) begin
      if (i % 4 == 0) b = 14'($urandom_range(9990, 10010));
      else            b = 14'($urandom_range(0, 16383));
      r = model(int'(b));
      do_conv(b, r[15:0], r[16]);
      prev = r[15:0];
    end

    // A start pulse in mid-conversion must be ignored; outputs hold until done.
    @(negedge clk);
    bin   = 14'd5678;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    first  = -1;
    n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1;
        bin   = 14'd1111;
      end
      if (k == 6) start = 1'b0;
      @(negedge clk);
      if (k == 10) chk("hold_during_shift", bcd, prev);
      if (done) begin
        n_done++;
        if (first < 0) begin
          first = k;
          chk("ignored_bcd", bcd, 16'h5678);
        end
      end
    end
    chk("ignored_done_count", n_done, 1);
    chk("ignored_latency", first, 14);

    // Back-to-back: next start presented on the done cycle.
    @(negedge clk);
    bin   = 14'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 0;
    while (!done && m < 40) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_first_lat", m, 14);
    chk("b2b_first_bcd", bcd, 16'h4321);
    bin   = 14'd8765;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 1;
    chk("b2b_busy", busy, 1);
    while (!done && m < 40) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_spacing", m, 15);
    chk("b2b_second_bcd", bcd, 16'h8765);

    // Reset mid-conversion clears outputs immediately and suppresses done.
    @(negedge clk);
    bin   = 14'd3000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_no_done", n_done, 0);
    do_conv(14'd3000, 16'h3000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
